piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter that is the sending end of the 4-bit serial shift path. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock, MSB-first or LSB-first. It supports hold (freeze) and abort (clear), and frames each word with `serial_valid` and `last`. Its `serial_out` drives the `serial_in` of the downstream universal shift register, so a WIDTH=4 word crosses that link in 4 shift cycles.

## Interface
- `WIDTH`, default 4: bits per word; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `inp`  in  WIDTH  parallel word to transmit.
- `in_valid`  in  1  `inp` is valid.
- `in_ready`  out  1  block accepts `inp` on this edge.
- `msb_first`  in  1  bit order, sampled only at load: 1 = bit WIDTH-1 first, 0 = bit 0 first.
- `hold`  in  1  freeze shifting; equivalent of the shift register's hold select.
- `abort`  in  1  drop the current word and return to IDLE.
- `serial_out`  out  1  current serial bit.
- `serial_valid`  out  1  `serial_out` is a data bit consumed on this edge.
- `last`  out  1  qualifies the final bit of a word.
- `busy`  out  1  a word is in flight (state SHIFT).

## Operation
- **Internal state:** WIDTH-bit shift register `shreg`, latched order bit `ord`, down-counter `cnt` of width clog2(WIDTH+1), and a 2-state FSM with states IDLE and SHIFT.
- **Reset:** state=IDLE, `shreg`=0, `cnt`=0, `ord`=0.
  - Outputs during and after reset: `busy`=0, `serial_valid`=0, `last`=0, `serial_out`=0, `in_ready`=1 (when `abort`=0).
- **Outputs, all combinational from registers plus `hold` and `abort`:**
  - `serial_out` = `ord` ? `shreg[WIDTH-1]` : `shreg[0]`.
  - `serial_valid` = SHIFT & !`hold` & !`abort`.
  - `last` = `serial_valid` & (`cnt`==1).
  - `in_ready` = !`abort` & (IDLE | `last`).
- **Load:** when `in_valid` & `in_ready` at an edge:
  - `shreg`<=`inp`, `ord`<=`msb_first`, `cnt`<=WIDTH, state<=SHIFT.
- **Shift:** in SHIFT with `serial_valid`=1, at each edge:
  - MSB-first: `shreg`<={`shreg[WIDTH-2:0]`,1'b0}. LSB-first: `shreg`<={1'b0,`shreg[WIDTH-1:1]`}.
  - `cnt`<=`cnt`-1.
  - Vacated bits fill with 0, so `shreg` is all-zero after the last bit.
- **End of word:** on the edge where `last`=1:
  - If `in_valid`=1, the next word loads on that same edge (load takes precedence over the shift). Result is zero-gap back-to-back streaming.
  - Otherwise state<=IDLE and `cnt`<=0.
- **Hold:** in SHIFT with `hold`=1 (and `abort`=0), all registers are frozen. `serial_out` keeps presenting the pending bit. In IDLE, `hold` has no effect and loads proceed.
- **Abort:** `abort`=1 at an edge gives state<=IDLE, `shreg`<=0, `cnt`<=0, and no load.
  - Priority: `reset` > `abort` > load > hold > shift.
- `inp` changes while not accepted are ignored. `msb_first` changes mid-word are ignored.

## Timing
- Load-to-first-bit latency is 1 cycle. Word accepted at edge N gives bits in cycles N+1 .. N+WIDTH when no holds occur.
- Each `hold` cycle adds exactly 1 cycle. Bit content and order are unchanged.
- Sustained throughput is 1 bit/clock with no idle cycle between words.
- Abort takes effect at the next edge. In the following cycle `busy`=0, `in_ready`=1, `serial_out`=0.
- Asynchronous reset takes effect with no clock. Reset asserted mid-word drops the word; `serial_valid` and `busy` fall immediately.
- `in_ready` and `serial_valid` have a combinational path from `abort`/`hold`. Driving logic must not loop them back combinationally.

## Test plan
- **Reset:** assert `reset` in the 2nd bit of a 4'b1111 word, between clock edges. Required: `busy`, `serial_valid`, `serial_out` go to 0 at once; `in_ready`=1 after release; no further bits emitted.
- **MSB-first:** WIDTH=4, load 4'b1011 with `msb_first`=1. Required: `serial_out` = 1,0,1,1 over 4 cycles, `serial_valid`=1 each cycle, `last` only on the 4th, then IDLE with `in_ready`=1.
- **LSB-first:** load 4'b1011 with `msb_first`=0. Required: `serial_out` = 1,1,0,1; `last` on the 4th bit.
- **Back-to-back:** 4'hA then 4'h5, MSB-first, with `in_valid` held high. Required: 8 contiguous valid bits 1,0,1,0,0,1,0,1; `last` on bits 4 and 8; `in_ready` high only in IDLE and on those two `last` cycles.
- **Hold:** 4'b1001 MSB-first, `hold`=1 for 2 cycles after bit 2. Required: `serial_valid`=0 and `serial_out`=0 (bit 3 pending) during hold; bits 3–4 = 0,1 afterwards; total 6 cycles.
- **Abort:** 4'b1100 MSB-first, `abort` pulsed during bit 3, with `in_valid` also high. Required: no load on that edge; next cycle `busy`=0, `in_ready`=1, `serial_out`=0; a fresh 4'b0110 then transmits correctly.

Source files
------------

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in, serial-out transmitter. It accepts a word over a
//               valid/ready handshake and sends it one bit per clock, MSB- or
//               LSB-first. It supports hold (freeze) and abort (clear), and
//               marks each word with serial_valid/last for zero-gap streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inp,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    input  logic             hold,
    input  logic             abort,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               ord_q,   ord_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               w_load;

    // Output decode. hold/abort gate the handshake combinationally, so the
    // bit in flight is only consumed when neither is asserted.
    always_comb begin
        busy         = (state_q == S_SHIFT);
        serial_out   = ord_q ? shreg_q[WIDTH-1] : shreg_q[0];
        serial_valid = (state_q == S_SHIFT) && !hold && !abort;
        last         = serial_valid && (cnt_q == CNT_W'(1));
        in_ready     = !abort && ((state_q == S_IDLE) || last);
        w_load       = in_valid && in_ready;
    end

    // Next-state logic. Priority: abort, then load (which also covers the
    // back-to-back case on the last bit), then shift. Hold simply leaves all
    // registers at their current values.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        ord_d   = ord_q;
        cnt_d   = cnt_q;

        if (abort) begin
            state_d = S_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (w_load) begin
            state_d = S_SHIFT;
            shreg_d = inp;
            ord_d   = msb_first;
            cnt_d   = CNT_W'(WIDTH);
        end else if (serial_valid) begin
            // Vacated positions fill with zero so the register ends all-zero.
            if (ord_q) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            ord_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed self-checking bench for piso_serializer (WIDTH=4).
//               Each cycle compares the packed output vector
//               {busy, in_ready, serial_valid, last, serial_out} against a
//               hand-computed value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] inp;
    logic             in_valid;
    logic             in_ready;
    logic             msb_first;
    logic             hold;
    logic             abort;
    logic             serial_out;
    logic             serial_valid;
    logic             last;
    logic             busy;

    logic [4:0]       w_obs;
    int               checks;
    int               failures;

    // Output encodings: {busy, in_ready, serial_valid, last, serial_out}
    localparam logic [4:0] C_IDLE   = 5'b01000;
    localparam logic [4:0] C_BIT0   = 5'b10100;
    localparam logic [4:0] C_BIT1   = 5'b10101;
    localparam logic [4:0] C_LAST0  = 5'b11110;
    localparam logic [4:0] C_LAST1  = 5'b11111;
    localparam logic [4:0] C_FROZEN = 5'b10000;

    piso_serializer #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .inp          (inp),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .msb_first    (msb_first),
        .hold         (hold),
        .abort        (abort),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .last         (last),
        .busy         (busy)
    );

    assign w_obs = {busy, in_ready, serial_valid, last, serial_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {busy,rdy,sv,last,so}=%b expected %b", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge, where new inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle mid-cycle, compare, then clock.
    task automatic step(input string tag, input logic [4:0] exp);
        #3;
        check_eq(tag, w_obs, exp);
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        inp       = '0;
        in_valid  = 1'b0;
        msb_first = 1'b0;
        hold      = 1'b0;
        abort     = 1'b0;

        #2;
        check_eq("reset_state", w_obs, C_IDLE);
        tick();
        tick();
        reset = 1'b0;
        step("post_reset_idle", C_IDLE);

        // MSB-first 1011 -> 1,0,1,1
        inp = 4'b1011; msb_first = 1'b1; in_valid = 1'b1;
        step("msb_load", C_IDLE);
        in_valid = 1'b0; msb_first = 1'b0; inp = 4'b0000;
        step("msb_b1", C_BIT1);
        step("msb_b2", C_BIT0);
        step("msb_b3", C_BIT1);
        step("msb_b4_last", C_LAST1);
        step("msb_idle", C_IDLE);

        // LSB-first 1011 -> 1,1,0,1 (msb_first toggled mid-word is ignored)
        inp = 4'b1011; msb_first = 1'b0; in_valid = 1'b1;
        step("lsb_load", C_IDLE);
        in_valid = 1'b0; msb_first = 1'b1;
        step("lsb_b1", C_BIT1);
        step("lsb_b2", C_BIT1);
        step("lsb_b3", C_BIT0);
        step("lsb_b4_last", C_LAST1);
        step("lsb_idle", C_IDLE);

        // Back-to-back A then 5, MSB-first -> 1,0,1,0,0,1,0,1
        inp = 4'hA; msb_first = 1'b1; in_valid = 1'b1;
        step("b2b_load_a", C_IDLE);
        inp = 4'h5;
        step("b2b_b1", C_BIT1);
        step("b2b_b2", C_BIT0);
        step("b2b_b3", C_BIT1);
        step("b2b_b4_last", C_LAST0);
        in_valid = 1'b0; inp = 4'hF;
        step("b2b_b5", C_BIT0);
        step("b2b_b6", C_BIT1);
        step("b2b_b7", C_BIT0);
        step("b2b_b8_last", C_LAST1);
        step("b2b_idle", C_IDLE);

        // Hold 2 cycles after bit 2 of 1001 MSB-first
        inp = 4'b1001; msb_first = 1'b1; in_valid = 1'b1;
        step("hold_load", C_IDLE);
        in_valid = 1'b0;
        step("hold_b1", C_BIT1);
        step("hold_b2", C_BIT0);
        hold = 1'b1;
        step("hold_frz1", C_FROZEN);
        step("hold_frz2", C_FROZEN);
        hold = 1'b0;
        step("hold_b3", C_BIT0);
        step("hold_b4_last", C_LAST1);
        step("hold_idle", C_IDLE);

        // Abort during bit 3 of 1100 with in_valid high, then send 0110
        inp = 4'b1100; msb_first = 1'b1; in_valid = 1'b1;
        step("abort_load", C_IDLE);
        in_valid = 1'b0;
        step("abort_b1", C_BIT1);
        step("abort_b2", C_BIT1);
        abort = 1'b1; in_valid = 1'b1; inp = 4'b0110;
        step("abort_pulse", C_FROZEN);
        abort = 1'b0; in_valid = 1'b0;
        step("abort_after", C_IDLE);
        inp = 4'b0110; in_valid = 1'b1;
        step("fresh_load", C_IDLE);
        in_valid = 1'b0;
        step("fresh_b1", C_BIT0);
        step("fresh_b2", C_BIT1);
        step("fresh_b3", C_BIT1);
        step("fresh_b4_last", C_LAST0);
        step("fresh_idle", C_IDLE);

        // Asynchronous reset in bit 2 of 1111
        inp = 4'b1111; msb_first = 1'b1; in_valid = 1'b1;
        step("rst_load", C_IDLE);
        in_valid = 1'b0;
        step("rst_b1", C_BIT1);
        #2;
        check_eq("rst_b2_before", w_obs, C_BIT1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_async", w_obs, C_IDLE);
        tick();
        reset = 1'b0;
        step("rst_rel1", C_IDLE);
        step("rst_rel2", C_IDLE);
        step("rst_rel3", C_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
